// File: rtl/pll_mode_reconfig.sv
// pll_mode_reconfig: N-mode PLL K-fraction reconfiguration sequencer over Avalon-MM to pll_hdmi_cfg.
// Optional lock wait with timeout when PLLCFG_LOCKWAIT_EN is defined.
module pll_mode_reconfig #(
  parameter int NUM_MODES     = 2,
  parameter int MODE_W        = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int LOCK_TIMEOUT  = 50000
) (
  input  logic                   CLK_50M,
  input  logic                   reset,
  input  logic [MODE_W-1:0]      mode_in,
  input  logic [NUM_MODES*32-1:0] frac_table,
  input  logic                   mgmt_waitrequest,
  output logic                   mgmt_write,
  output logic [5:0]             mgmt_address,
  output logic [31:0]            mgmt_writedata,
  input  logic                   pll_locked,
  output logic                   busy,
  output logic [MODE_W-1:0]      applied_mode,
  output logic                   lock_timeout
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);
  typedef enum logic [2:0] {IDLE, WR_MODE, WR_FRAC, WR_START, WAIT_LOCK} state_t;
  state_t            state;
  logic [MODE_W-1:0] mode_m, mode_s, tgt;
  logic [CW-1:0]     cnt;
  logic              programmed, launch;
  logic [31:0]       frac [NUM_MODES];
  for (genvar i = 0; i < NUM_MODES; i++) begin : g_frac
    assign frac[i] = frac_table[32*i +: 32];
  end
  assign launch = cnt == SC && 32'(mode_s) < 32'(NUM_MODES) && (mode_s != applied_mode || !programmed);
  // Counter clears in the same cycle mode_s takes a new value.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      mode_m <= '0;
      mode_s <= '0;
      cnt    <= '0;
    end else begin
      mode_m <= mode_in;
      mode_s <= mode_m;
      cnt    <= mode_m != mode_s ? '0 : cnt == SC ? cnt : cnt + 1'b1;
    end
  end
`ifdef PLLCFG_LOCKWAIT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1) < 4 ? 4 : $clog2(LOCK_TIMEOUT + 1);
  logic          lock_m, lock_s, lock_ok;
  logic [TW-1:0] wcnt;
  assign lock_ok = wcnt >= TW'(7) && lock_s;
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end
`else
  logic unused_lock;
  assign unused_lock  = pll_locked;
  assign lock_timeout = 1'b0;
`endif
  // Each WR_* state issues its write when mgmt_write is low, so the cycle after acceptance is idle.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state          <= IDLE;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      applied_mode   <= '0;
      programmed     <= 1'b0;
      tgt            <= '0;
`ifdef PLLCFG_LOCKWAIT_EN
      lock_timeout   <= 1'b0;
      wcnt           <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (launch) begin
          tgt            <= mode_s;
          state          <= WR_MODE;
          mgmt_write     <= 1'b1;
          mgmt_address   <= 6'd0;
          mgmt_writedata <= '0;
          busy           <= 1'b1;
`ifdef PLLCFG_LOCKWAIT_EN
          lock_timeout   <= 1'b0;
`endif
        end
        WR_MODE: if (!mgmt_waitrequest) begin
          mgmt_write <= 1'b0;
          state      <= WR_FRAC;
        end
        WR_FRAC: if (!mgmt_write) begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= 6'd7;
          mgmt_writedata <= frac[tgt];
        end else if (!mgmt_waitrequest) begin
          mgmt_write <= 1'b0;
          state      <= WR_START;
        end
        WR_START: if (!mgmt_write) begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= 6'd2;
          mgmt_writedata <= '0;
        end else if (!mgmt_waitrequest) begin
          mgmt_write <= 1'b0;
`ifdef PLLCFG_LOCKWAIT_EN
          state      <= WAIT_LOCK;
          wcnt       <= '0;
`else
          state        <= IDLE;
          applied_mode <= tgt;
          programmed   <= 1'b1;
          busy         <= 1'b0;
`endif
        end
`ifdef PLLCFG_LOCKWAIT_EN
        WAIT_LOCK: begin
          wcnt <= wcnt + 1'b1;
          if (lock_ok || wcnt == TW'(LOCK_TIMEOUT - 1)) begin
            lock_timeout <= !lock_ok;
            state        <= IDLE;
            applied_mode <= tgt;
            programmed   <= 1'b1;
            busy         <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_mode_reconfig.sv
// tb_pll_mode_reconfig: scoreboard bench; expected Avalon writes queued at stimulus, popped on acceptance.
module tb_pll_mode_reconfig;
  localparam logic [31:0] K0 = 32'h29E2B79B;
  localparam logic [31:0] K1 = 32'h15448515;
  logic        CLK_50M = 1'b0, reset = 1'b1, mgmt_waitrequest = 1'b0, pll_locked = 1'b1;
  logic [0:0]  mode_in = 1'b0;
  logic [63:0] frac_table = {K1, K0};
  logic        mgmt_write, busy, lock_timeout;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [0:0]  applied_mode;
  int          tests = 0, fails = 0, accepted = 0, wr_cycles = 0;
  logic [37:0] exp_q[$];
  logic        prev_hold = 1'b0, prev_acc = 1'b0;
  logic [37:0] held;

  pll_mode_reconfig dut (
    .CLK_50M(CLK_50M), .reset(reset), .mode_in(mode_in), .frac_table(frac_table),
    .mgmt_waitrequest(mgmt_waitrequest), .mgmt_write(mgmt_write), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .pll_locked(pll_locked), .busy(busy),
    .applied_mode(applied_mode), .lock_timeout(lock_timeout)
  );

  always #10 CLK_50M = ~CLK_50M;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] k);
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd7, k});
    exp_q.push_back({6'd2, 32'd0});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK_50M);
    #1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    for (k = 0; k < bound && (busy || exp_q.size() != 0); k++) tick();
    check(tag, k < bound, 1);
  endtask

  task automatic wait_busy(input string tag);
    int k;
    for (k = 0; k < 100 && !busy; k++) tick();
    check(tag, k < 100, 1);
  endtask

  always @(negedge CLK_50M) begin
    if (reset) begin
      prev_hold = 1'b0;
      prev_acc  = 1'b0;
    end else begin
      if (prev_acc) check("gap", mgmt_write, 0);
      if (prev_hold) check("hold", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, held});
      if (mgmt_write) wr_cycles++;
      if (mgmt_write && !mgmt_waitrequest) begin
        accepted++;
        if (exp_q.size() == 0) check("unexpected_wr", exp_q.size(), 1);
        else check("wr", {mgmt_address, mgmt_writedata}, exp_q.pop_front());
      end
      prev_hold = mgmt_write && mgmt_waitrequest;
      prev_acc  = mgmt_write && !mgmt_waitrequest;
      held      = {mgmt_address, mgmt_writedata};
    end
  end

  initial begin
    int n, a0, w0;
    tick(3);
    check("rst_write", mgmt_write, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_data", mgmt_writedata, 0);
    check("rst_busy", busy, 0);
    check("rst_applied", applied_mode, 0);
    check("rst_timeout", lock_timeout, 0);
    // first stable mode after reset programs even though it equals applied_mode
    push_seq(K0);
    reset = 1'b0;
    wait_done("t1_done", 500);
    check("t1_applied", applied_mode, 0);
    check("t1_count", accepted, 3);
    // mode 0 -> 1: first write STABLE_CYCLES+3 edges after the change
    a0 = accepted;
    mode_in = 1'b1;
    push_seq(K1);
    for (n = 1; n < 50 && !mgmt_write; n++) tick();
    check("t2_latency", n - 1, 7);
    wait_done("t2_done", 500);
    check("t2_applied", applied_mode, 1);
    check("t2_count", accepted - a0, 3);
    // stall WR_FRAC for 10 cycles
    a0 = accepted;
    mode_in = 1'b0;
    push_seq(K0);
    for (n = 0; n < 100 && !(mgmt_write && mgmt_address == 6'd7); n++) tick();
    check("t3_frac_seen", n < 100, 1);
    mgmt_waitrequest = 1'b1;
    repeat (10) begin
      check("t3_stall", {mgmt_write, mgmt_address}, {1'b1, 6'd7});
      tick();
    end
    mgmt_waitrequest = 1'b0;
    wait_done("t3_done", 500);
    check("t3_count", accepted - a0, 3);
    check("t3_applied", applied_mode, 0);
    // two-cycle glitch must not launch
    w0 = wr_cycles;
    mode_in = 1'b1;
    tick(2);
    mode_in = 1'b0;
    tick(30);
    check("t4_glitch", wr_cycles - w0, 0);
    check("t4_applied", applied_mode, 0);
    // change mode while busy: old sequence completes, then relaunch
    a0 = accepted;
    mode_in = 1'b1;
    push_seq(K1);
    wait_busy("t5_busy");
    mode_in = 1'b0;
    push_seq(K0);
    wait_done("t5_done", 1000);
    check("t5_count", accepted - a0, 6);
    check("t5_applied", applied_mode, 0);
    // reset while a write is held
    mgmt_waitrequest = 1'b1;
    mode_in = 1'b1;
    for (n = 0; n < 100 && !mgmt_write; n++) tick();
    check("t6_write_seen", n < 100, 1);
    tick(3);
    check("t6_held", mgmt_write, 1);
    reset = 1'b1;
    tick();
    check("t6_rst_write", mgmt_write, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_applied", applied_mode, 0);
    tick(2);
    mgmt_waitrequest = 1'b0;
    push_seq(K1);
    reset = 1'b0;
    wait_done("t6_done", 500);
    check("t6_applied", applied_mode, 1);
`ifdef PLLCFG_LOCKWAIT_EN
    pll_locked = 1'b0;
    mode_in = 1'b0;
    push_seq(K0);
    wait_done("t7_done", 60000);
    check("t7_timeout", lock_timeout, 1);
    check("t7_applied", applied_mode, 0);
    pll_locked = 1'b1;
    mode_in = 1'b1;
    push_seq(K1);
    wait_busy("t7_busy");
    check("t7_cleared", lock_timeout, 0);
    wait_done("t7_done2", 500);
    check("t7_applied2", applied_mode, 1);
`else
    check("no_timeout", lock_timeout, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
